// File: rtl/mux_pkg.sv
// Shared definitions for the 4-to-1 round-robin merging multiplexer.
package mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Channel pointer advance; relies on the 2-bit width to wrap 3 -> 0.
  function automatic sel_t next_ptr(sel_t p);
    return sel_t'(p + sel_t'(1));
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational rotating-priority arbiter over four requesters.
// The search starts one past last_grant so the previous winner gets lowest priority.
module rr_arb4
  import mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            last_grant,
  output sel_t            gnt_idx,
  output logic            any_req
);

  sel_t idx;
  logic found;

  // Walk the four channels in rotated order; the first requester wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = last_grant;
    for (int k = 0; k < N_CH; k++) begin
      idx = next_ptr(idx);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux_rr_4to1.sv
// 4-to-1 valid/ready merging mux with round-robin arbitration and a
// registered output stage. mux_signal tags each word with its source channel.
module mux_rr_4to1
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] mux_in,
  input  logic [N_CH-1:0]        mux_in_valid,
  output logic [N_CH-1:0]        mux_in_ready,
  output logic [DATA_W-1:0]      mux_out,
  output logic                   mux_out_valid,
  input  logic                   mux_out_ready,
  output logic [SEL_W-1:0]       mux_signal
);

  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]           out_q, out_d;
  logic                        vld_q, vld_d;
  sel_t                        sel_q, sel_d;
  sel_t                        last_q, last_d;
  sel_t                        gnt_idx;
  logic                        any_req;
  logic                        load;

  assign ch_data = mux_in;

  rr_arb4 u_arb (
    .req        (mux_in_valid),
    .last_grant (last_q),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  // The output register can accept a word when empty or being drained this cycle.
  assign load = !vld_q || mux_out_ready;

  // Per-channel ready: only the arbitration winner sees ready, and only when loading.
  for (genvar g = 0; g < N_CH; g++) begin : g_rdy
    assign mux_in_ready[g] = load && any_req && (gnt_idx == sel_t'(g));
  end

  // Next-state for the output stage and the arbitration pointer.
  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    sel_d  = sel_q;
    last_d = last_q;
    if (load) begin
      vld_d = any_req;
      if (any_req) begin
        out_d  = ch_data[gnt_idx];
        sel_d  = gnt_idx;
        last_d = gnt_idx;
      end
    end
  end

  // last_grant resets to 3 so channel 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      sel_q  <= '0;
      last_q <= sel_t'(N_CH - 1);
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

  assign mux_out       = out_q;
  assign mux_out_valid = vld_q;
  assign mux_signal    = sel_q;

endmodule

// File: tb/tb_mux_rr_4to1.sv
// Directed bench for mux_rr_4to1: expected words are queued at handshake
// time and popped when the output stage hands a word downstream.
module tb_mux_rr_4to1;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] din;
  logic [3:0]      vin;
  logic [3:0]      rin;
  logic [7:0]      dout;
  logic            vout;
  logic            rout;
  logic [1:0]      sig;

  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  exp_t sb[$];

  mux_rr_4to1 #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mux_in        (din),
    .mux_in_valid  (vin),
    .mux_in_ready  (rin),
    .mux_out       (dout),
    .mux_out_valid (vout),
    .mux_out_ready (rout),
    .mux_signal    (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream side: every word leaving the register must match the queue head.
  always @(negedge clk) begin
    if (rst_n && vout && rout) begin
      pops++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(dout), 32'(e.d));
        chk("sb_sel",  32'(sig),  32'(e.s));
      end
    end
  end

  // One cycle: drive at posedge+1, check ready at negedge, queue the expected word.
  task automatic cyc(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                     input logic [7:0] exp_d, input logic [1:0] exp_s);
    exp_t e;
    vin  = v;
    rout = ordy;
    @(negedge clk);
    chk("in_ready", 32'(rin), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e.d = exp_d;
      e.s = exp_s;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, 32'(vout), 32'(v));
    chk({tag, "_data"},  32'(dout), 32'(d));
    chk({tag, "_sel"},   32'(sig),  32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    vin   = '0;
    rout  = 1'b0;
    #3;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single source on ch2.
    din[2] = 8'hA5;
    cyc(4'b0100, 1'b1, 4'b0100, 8'hA5, 2'd2);
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // Idle: valid drops, sel and data hold.
    cyc(4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);
    chk_out("idle", 1'b0, 8'hA5, 2'd2);

    // Wrap and skip.
    din[3] = 8'h33;
    din[1] = 8'h11;
    din[0] = 8'hC0;
    cyc(4'b1000, 1'b1, 4'b1000, 8'h33, 2'd3);
    cyc(4'b1010, 1'b1, 4'b0010, 8'h11, 2'd1);
    cyc(4'b1000, 1'b1, 4'b1000, 8'h33, 2'd3);
    cyc(4'b0001, 1'b1, 4'b0001, 8'hC0, 2'd0);
    cyc(4'b0001, 1'b1, 4'b0001, 8'hC0, 2'd0);
    chk_out("repeat_ch0", 1'b1, 8'hC0, 2'd0);

    // Backpressure: 3C held for 5 stalled cycles while ch1 has 4D pending.
    din[1] = 8'h3C;
    cyc(4'b0010, 1'b1, 4'b0010, 8'h3C, 2'd1);
    din[1] = 8'h4D;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0010, 1'b0, 4'b0000, 8'h00, 2'd0);
      chk_out("stall", 1'b1, 8'h3C, 2'd1);
    end
    cyc(4'b0010, 1'b1, 4'b0010, 8'h4D, 2'd1);
    chk_out("release", 1'b1, 8'h4D, 2'd1);
    cyc(4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);

    // Full contention, starting after grant 1, then reset mid-stream.
    for (int i = 0; i < 4; i++) din[i] = 8'(i * 16);
    cyc(4'b1111, 1'b1, 4'b0100, 8'h20, 2'd2);
    cyc(4'b1111, 1'b1, 4'b1000, 8'h30, 2'd3);
    cyc(4'b1111, 1'b1, 4'b0001, 8'h00, 2'd0);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 8'h00, 2'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1111, 1'b1, 4'b0001, 8'h00, 2'd0);
    cyc(4'b1111, 1'b1, 4'b0010, 8'h10, 2'd1);
    cyc(4'b1111, 1'b1, 4'b0100, 8'h20, 2'd2);
    cyc(4'b1111, 1'b1, 4'b1000, 8'h30, 2'd3);
    cyc(4'b1111, 1'b1, 4'b0001, 8'h00, 2'd0);
    cyc(4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);
    chk_out("drain", 1'b0, 8'h00, 2'd0);
    cyc(4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("pop_count", 32'(pops), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
